// File: rtl/conv_window_read_sequencer_if.sv
// Read-side bundle of the convolution window sequencer: RAM read port plus the
// pixel stream (valid/ready with window/frame markers) towards the MAC array.
interface conv_window_read_sequencer_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [7:0]        ram_data;
    logic [7:0]        pix_data;
    logic              pix_vld;
    logic              pix_rdy;
    logic              pix_last;
    logic              frame_last;
    logic [9:0]        win_row;
    logic [6:0]        win_col;

    modport master (
        output ram_addr,
        output ram_re,
        input  ram_data,
        output pix_data,
        output pix_vld,
        input  pix_rdy,
        output pix_last,
        output frame_last,
        output win_row,
        output win_col
    );

    modport slave (
        input  ram_addr,
        input  ram_re,
        output ram_data,
        input  pix_data,
        input  pix_vld,
        output pix_rdy,
        input  pix_last,
        input  frame_last,
        input  win_row,
        input  win_col
    );
endinterface

// File: rtl/conv_window_read_sequencer.sv
// Scans a row-major IMG_H x IMG_W feature map as K x K stride-1 windows, one RAM read
// per cycle, streaming pixels with window/frame markers over a valid/ready handshake.
module conv_window_read_sequencer #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned IMG_W  = 5,
    parameter int unsigned IMG_H  = 4,
    parameter int unsigned K      = 3,
    parameter int unsigned BASE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    conv_window_read_sequencer_if.master  bus
);

    localparam logic [2:0]        KLast       = 3'(K - 1);
    localparam logic [6:0]        OcolLast    = 7'(IMG_W - K);
    localparam logic [9:0]        OrowLast    = 10'(IMG_H - K);
    localparam logic [ADDR_W-1:0] BaseAddr    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] AddrOne     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RowStep     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] RowWrapStep = ADDR_W'(K);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Scan counters describe the read that will be issued next.
    logic [2:0] kc_q, kc_d;
    logic [2:0] kr_q, kr_d;
    logic [6:0] ocol_q, ocol_d;
    logic [9:0] orow_q, orow_d;

    // addr_q: next read; row_ptr_q: start of current kernel row; win_ptr_q: window origin.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [ADDR_W-1:0] win_ptr_q, win_ptr_d;

    // Sideband registered with each read so it lines up with the RAM output register.
    logic       vld_q, vld_d;
    logic       last_q, last_d;
    logic       flast_q, flast_d;
    logic [9:0] win_row_q, win_row_d;
    logic [6:0] win_col_q, win_col_d;

    logic issue;
    logic hs;
    logic kc_wrap;
    logic kr_wrap;
    logic ocol_wrap;
    logic final_rd;

    assign kc_wrap   = (kc_q == KLast);
    assign kr_wrap   = (kr_q == KLast);
    assign ocol_wrap = (ocol_q == OcolLast);
    assign final_rd  = kc_wrap & kr_wrap & ocol_wrap & (orow_q == OrowLast);

    // A read may issue whenever the output slot is empty or being emptied this cycle.
    assign issue = (state_q == StRun) & (~vld_q | bus.pix_rdy);
    assign hs    = vld_q & bus.pix_rdy;

    always_comb begin
        state_d   = state_q;
        kc_d      = kc_q;
        kr_d      = kr_q;
        ocol_d    = ocol_q;
        orow_d    = orow_q;
        addr_d    = addr_q;
        row_ptr_d = row_ptr_q;
        win_ptr_d = win_ptr_q;
        last_d    = last_q;
        flast_d   = flast_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        vld_d     = issue | (vld_q & ~bus.pix_rdy);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    kc_d      = '0;
                    kr_d      = '0;
                    ocol_d    = '0;
                    orow_d    = '0;
                    addr_d    = BaseAddr;
                    row_ptr_d = BaseAddr;
                    win_ptr_d = BaseAddr;
                end
            end

            StRun: begin
                if (issue) begin
                    last_d    = kc_wrap & kr_wrap;
                    flast_d   = final_rd;
                    win_row_d = orow_q;
                    win_col_d = ocol_q;
                    if (final_rd) begin
                        state_d = StDrain;
                    end else if (!kc_wrap) begin
                        kc_d   = kc_q + 3'd1;
                        addr_d = addr_q + AddrOne;
                    end else if (!kr_wrap) begin
                        kc_d      = '0;
                        kr_d      = kr_q + 3'd1;
                        row_ptr_d = row_ptr_q + RowStep;
                        addr_d    = row_ptr_q + RowStep;
                    end else if (!ocol_wrap) begin
                        kc_d      = '0;
                        kr_d      = '0;
                        ocol_d    = ocol_q + 7'd1;
                        win_ptr_d = win_ptr_q + AddrOne;
                        row_ptr_d = win_ptr_q + AddrOne;
                        addr_d    = win_ptr_q + AddrOne;
                    end else begin
                        // Last window of a row: origin jumps past the K-1 unused columns.
                        kc_d      = '0;
                        kr_d      = '0;
                        ocol_d    = '0;
                        orow_d    = orow_q + 10'd1;
                        win_ptr_d = win_ptr_q + RowWrapStep;
                        row_ptr_d = win_ptr_q + RowWrapStep;
                        addr_d    = win_ptr_q + RowWrapStep;
                    end
                end
            end

            StDrain: begin
                if (hs) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            kc_q      <= '0;
            kr_q      <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            addr_q    <= '0;
            row_ptr_q <= '0;
            win_ptr_q <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            flast_q   <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            state_q   <= state_d;
            kc_q      <= kc_d;
            kr_q      <= kr_d;
            ocol_q    <= ocol_d;
            orow_q    <= orow_d;
            addr_q    <= addr_d;
            row_ptr_q <= row_ptr_d;
            win_ptr_q <= win_ptr_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            flast_q   <= flast_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign busy_o         = (state_q == StRun) | (state_q == StDrain);
    assign done_o         = (state_q == StDone);
    assign bus.ram_re     = issue;
    assign bus.ram_addr   = addr_q;
    assign bus.pix_data   = bus.ram_data;
    assign bus.pix_vld    = vld_q;
    assign bus.pix_last   = last_q;
    assign bus.frame_last = flast_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule
